capture_ctl: RTL

- Bus-mapped sequencer for the ADC capture path.
- Drives the ADC reader enable, optionally aligns the capture start to a PPS edge, and counts a programmed number of samples before stopping.
- Counting uses the ADC reader's output-valid strobe.
- Sits on the internal register bus alongside the other register blocks. Its `adc_enable` output replaces the direct ADC-control register bit.

---
 rtl/capture_ctl_pkg.sv | 25 ++
 rtl/capture_ctl_edge_rise.sv | 19 +
 rtl/capture_ctl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/capture_ctl_pkg.sv
// Shared definitions for the ADC capture sequencer: register offsets,
// CTRL bit positions and the state encoding visible in STATUS[1:0].
package capture_ctl_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_COUNT0 = 3'd2;
  localparam logic [2:0] OFF_COUNT1 = 3'd3;
  localparam logic [2:0] OFF_COUNT2 = 3'd4;
  localparam logic [2:0] OFF_CAPT0  = 3'd5;
  localparam logic [2:0] OFF_CAPT1  = 3'd6;
  localparam logic [2:0] OFF_CAPT2  = 3'd7;

  localparam int CTRL_ARM      = 0;
  localparam int CTRL_PPS_SYNC = 1;
  localparam int CTRL_ABORT    = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PPS = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/capture_ctl_edge_rise.sv
// Registered rising-edge detector: o_rise is high while i_d is 1 and its
// value at the previous clock was 0.
module edge_rise (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_prev <= 1'b0;
    else         r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/capture_ctl.sv
// Bus-mapped ADC capture sequencer: arms on a CTRL write, optionally waits
// for a PPS edge, then counts reader output-valid strobes until done or abort.
module capture_ctl
  import capture_ctl_pkg::*;
#(
  parameter logic [7:0] BASEADDR = 8'h20,
  parameter int         COUNT_W  = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  inout  wire  [7:0] data,
  input  logic       rd,
  input  logic       wr,
  input  logic       sample_valid,
  input  logic       pps,
  output logic       adc_enable,
  output logic       capture_active,
  output logic       done_pulse
);

  state_t             r_state;
  logic               r_pps_sync;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_remain;
  logic               r_free_run;
  logic [COUNT_W-1:0] r_captured;
  logic [15:0]        r_shadow;
  logic               r_done;
  logic               r_aborted;
  logic               r_rd_q;
  logic               r_adc_enable;
  logic               r_capture_active;
  logic               r_done_pulse;

  logic [7:0]         w_off;
  logic               w_in_win;
  logic [2:0]         w_reg;
  logic               w_wr_hit;
  logic               w_ctrl_wr;
  logic               w_arm;
  logic               w_abort;
  logic               w_pps_rise;
  logic [COUNT_W-1:0] w_capt_inc;
  logic [7:0]         w_rd_data;

  edge_rise u_pps_edge (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (pps),
    .o_rise  (w_pps_rise)
  );

  // Addresses below BASEADDR wrap to large offsets and fall outside the window.
  assign w_off      = address - BASEADDR;
  assign w_in_win   = (w_off < 8'd8);
  assign w_reg      = w_off[2:0];
  assign w_wr_hit   = wr & w_in_win;
  assign w_ctrl_wr  = w_wr_hit & (w_reg == OFF_CTRL);
  assign w_abort    = w_ctrl_wr & data[CTRL_ABORT];
  assign w_arm      = w_ctrl_wr & data[CTRL_ARM] & ~data[CTRL_ABORT];
  assign w_capt_inc = (r_captured == {COUNT_W{1'b1}}) ? r_captured
                                                      : r_captured + COUNT_W'(1);

  always_comb begin
    w_rd_data = 8'h00;
    case (w_reg)
      OFF_CTRL:   w_rd_data = {6'b0, r_pps_sync, 1'b0};
      OFF_STATUS: w_rd_data = {4'b0, r_aborted, r_done, r_state};
      OFF_COUNT0: w_rd_data = r_count[7:0];
      OFF_COUNT1: w_rd_data = r_count[15:8];
      OFF_COUNT2: w_rd_data = r_count[23:16];
      OFF_CAPT0:  w_rd_data = r_captured[7:0];
      OFF_CAPT1:  w_rd_data = r_shadow[7:0];
      OFF_CAPT2:  w_rd_data = r_shadow[15:8];
      default:    w_rd_data = 8'h00;
    endcase
  end

  assign data = (rd && w_in_win) ? w_rd_data : 8'hzz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_pps_sync       <= 1'b0;
      r_count          <= '0;
      r_remain         <= '0;
      r_free_run       <= 1'b0;
      r_captured       <= '0;
      r_shadow         <= '0;
      r_done           <= 1'b0;
      r_aborted        <= 1'b0;
      r_rd_q           <= 1'b0;
      r_adc_enable     <= 1'b0;
      r_capture_active <= 1'b0;
      r_done_pulse     <= 1'b0;
    end else begin
      r_rd_q       <= rd;
      r_done_pulse <= 1'b0;
      if (w_ctrl_wr) r_pps_sync <= data[CTRL_PPS_SYNC];
      if (w_wr_hit) begin
        case (w_reg)
          OFF_COUNT0: r_count[7:0]   <= data;
          OFF_COUNT1: r_count[15:8]  <= data;
          OFF_COUNT2: r_count[23:16] <= data;
          default: ;
        endcase
      end
      // Low byte of CAPTURED is read live; upper bytes are frozen for +6/+7.
      if (rd && !r_rd_q && w_in_win && (w_reg == OFF_CAPT0))
        r_shadow <= r_captured[23:8];
      if (sample_valid && (r_state == ST_RUN)) r_captured <= w_capt_inc;

      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            r_remain         <= r_count;
            r_free_run       <= (r_count == '0);
            r_captured       <= '0;
            r_done           <= 1'b0;
            r_aborted        <= 1'b0;
            r_capture_active <= 1'b1;
            r_adc_enable     <= ~data[CTRL_PPS_SYNC];
            r_state          <= data[CTRL_PPS_SYNC] ? ST_WAIT_PPS : ST_RUN;
          end
        end
        ST_WAIT_PPS: begin
          if (w_abort) begin
            r_aborted        <= 1'b1;
            r_capture_active <= 1'b0;
            r_state          <= ST_IDLE;
          end else if (w_pps_rise) begin
            r_adc_enable <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_aborted        <= 1'b1;
            r_adc_enable     <= 1'b0;
            r_capture_active <= 1'b0;
            r_state          <= ST_IDLE;
          end else if (sample_valid && !r_free_run) begin
            r_remain <= r_remain - COUNT_W'(1);
            if (r_remain == COUNT_W'(1)) begin
              r_done           <= 1'b1;
              r_done_pulse     <= 1'b1;
              r_adc_enable     <= 1'b0;
              r_capture_active <= 1'b0;
              r_state          <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign adc_enable     = r_adc_enable;
  assign capture_active = r_capture_active;
  assign done_pulse     = r_done_pulse;

endmodule
